// File: rtl/gpu_buf_pkg.sv
// Shared types for the mini-GPU buffer arbiter: request opcodes, FSM states
// and an index-width helper.
package gpu_buf_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_READ = 2'b10,
        OP_BAD  = 2'b11
    } buf_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/circular_buffer.sv
// Circular FIFO with registered read port; pop advances head, read peeks.
// One slot stays unused so head == tail always means empty.
module circular_buffer #(
    parameter  int  DEPTH = 16,
    parameter  type T     = logic [31:0],
    localparam int  AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_buffer,
    input  logic pop_buffer,
    input  logic read_buffer,
    input  T     data_in,
    output T     data_out,
    output logic full,
    output logic empty,
    output logic overflow
);

    T               mem [DEPTH];
    logic [AW-1:0]  head_reg;
    logic [AW-1:0]  tail_reg;
    logic [AW-1:0]  head_next;
    logic [AW-1:0]  tail_next;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign head_next = wrap_inc(head_reg);
    assign tail_next = wrap_inc(tail_reg);
    assign empty     = (head_reg == tail_reg);
    assign full      = (tail_next == head_reg);

    always_ff @(posedge clk) begin
        if (push_buffer && !full) begin
            mem[tail_reg] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
            data_out <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_buffer) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    tail_reg <= tail_next;
                end
            end
            if (pop_buffer || read_buffer) begin
                data_out <= mem[head_reg];
            end
            if (pop_buffer && !empty) begin
                head_reg <= head_next;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter
    import gpu_buf_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin : p_pick
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Scan from the farthest offset back to ptr so the nearest eligible one wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (eligible[cand]) begin
                grant_idx = IDX_W'(cand);
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Shares one circular_buffer among NUM_REQ requesters: round-robin accept,
// one strobe per operation, own occupancy tracking, response routing.
module buffer_arbiter
    import gpu_buf_pkg::*;
#(
    parameter  int  NUM_REQ = 4,
    parameter  int  DEPTH   = 16,
    parameter  type T       = logic [31:0],
    localparam int  CNT_W   = $clog2(DEPTH) + 1,
    localparam int  IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [1:0]         req_op   [NUM_REQ],
    input  T                   req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    output T                   rsp_data,
    output logic               rsp_err,
    output logic               buf_push,
    output logic               buf_pop,
    output logic               buf_read,
    output T                   buf_data_in,
    input  T                   buf_data_out,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    arb_state_e         state_reg;
    buf_op_e            op_reg;
    logic [IDX_W-1:0]   id_reg;
    logic [IDX_W-1:0]   ptr_reg;
    T                   data_reg;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    assign full  = (count == CNT_W'(DEPTH - 1));
    assign empty = (count == '0);

    // Ineligible requests simply drop out of the mask and stay pending.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = req_valid[gi] &&
                ((req_op[gi] == OP_PUSH) ? !full  :
                 (req_op[gi] == OP_BAD)  ? 1'b1   : !empty);
        end
    endgenerate

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready   = (state_reg == S_IDLE && !rst) ? grant : '0;
    assign buf_data_in = buf_push ? data_reg : '0;
    assign rsp_data    = ((|rsp_valid) && (op_reg == OP_POP || op_reg == OP_READ))
                         ? buf_data_out : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_PUSH;
            id_reg    <= '0;
            ptr_reg   <= '0;
            data_reg  <= '0;
            count     <= '0;
            buf_push  <= 1'b0;
            buf_pop   <= 1'b0;
            buf_read  <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
        end else begin
            buf_push  <= 1'b0;
            buf_pop   <= 1'b0;
            buf_read  <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (grant_any) begin
                        op_reg    <= buf_op_e'(req_op[grant_idx]);
                        id_reg    <= grant_idx;
                        data_reg  <= req_data[grant_idx];
                        ptr_reg   <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                        // Strobes are registered here so they are high exactly during ISSUE.
                        buf_push  <= (req_op[grant_idx] == OP_PUSH);
                        buf_pop   <= (req_op[grant_idx] == OP_POP);
                        buf_read  <= (req_op[grant_idx] == OP_READ);
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (buf_push) begin
                        count <= count + 1'b1;
                    end else if (buf_pop) begin
                        count <= count - 1'b1;
                    end
                    rsp_valid[id_reg] <= 1'b1;
                    rsp_err           <= (op_reg == OP_BAD);
                    state_reg         <= S_RESP;
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter + circular_buffer: directed scenarios then random
// traffic, all checked against a queue-based model of the shared buffer.
module tb_buffer_arbiter;

    localparam int NR    = 4;
    localparam int DEPTH = 16;
    typedef logic [31:0] word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid;
    logic [1:0]    req_op   [NR];
    word_t         req_data [NR];
    logic [NR-1:0] req_ready;
    logic [NR-1:0] rsp_valid;
    word_t         rsp_data;
    logic          rsp_err;
    logic          buf_push, buf_pop, buf_read;
    word_t         buf_data_in, buf_data_out;
    logic [4:0]    count;
    logic          full, empty;
    logic          cb_full, cb_empty, cb_overflow;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    ptr_m    = 0;
    word_t q[$];

    always #5 clk = ~clk;

    buffer_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .T(word_t)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .buf_push     (buf_push),
        .buf_pop      (buf_pop),
        .buf_read     (buf_read),
        .buf_data_in  (buf_data_in),
        .buf_data_out (buf_data_out),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    circular_buffer #(.DEPTH(DEPTH), .T(word_t)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_buffer (buf_push),
        .pop_buffer  (buf_pop),
        .read_buffer (buf_read),
        .data_in     (buf_data_in),
        .data_out    (buf_data_out),
        .full        (cb_full),
        .empty       (cb_empty),
        .overflow    (cb_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit op_ok(input logic [1:0] op);
        case (op)
            2'b00:   return q.size() < DEPTH - 1;
            2'b11:   return 1'b1;
            default: return q.size() > 0;
        endcase
    endfunction

    function automatic int predict();
        for (int off = 0; off < NR; off++) begin
            int c = (ptr_m + off) % NR;
            if (req_valid[c] && op_ok(req_op[c])) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int r, input logic [1:0] op, input word_t d);
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_data[r]  = d;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check({tag, "/ready"}, req_ready, 0);
        check({tag, "/strobes"}, {buf_push, buf_pop, buf_read}, 0);
        check({tag, "/rsp_valid"}, rsp_valid, 0);
        check({tag, "/rsp_err"}, rsp_err, 0);
        check({tag, "/rsp_data"}, rsp_data, 0);
        check({tag, "/count"}, count, 0);
        check({tag, "/empty"}, empty, 1);
        check({tag, "/full"}, full, 0);
        rst = 1'b0;
        q.delete();
        ptr_m = 0;
    endtask

    // One accept/issue/respond transaction (or a few idle cycles if nothing is eligible).
    task automatic step(input string tag, input bit rst_in_issue = 1'b0);
        int         w;
        logic [1:0] op;
        word_t      d;
        word_t      exp_data;
        logic [2:0] exp_strb;
        #1;
        w = predict();
        if (w < 0) begin
            for (int k = 0; k < 4; k++) begin
                check({tag, "/no_grant_ready"}, req_ready, 0);
                check({tag, "/no_grant_strobes"}, {buf_push, buf_pop, buf_read}, 0);
                @(negedge clk);
                #1;
            end
            $display("step %s: no eligible request, count=%0d", tag, q.size());
            return;
        end
        op = req_op[w];
        d  = req_data[w];
        check({tag, "/ready"}, req_ready, NR'(1) << w);
        ptr_m = (w + 1) % NR;
        @(negedge clk);
        #1;
        exp_strb = (op == 2'b00) ? 3'b100 : (op == 2'b01) ? 3'b010 :
                   (op == 2'b10) ? 3'b001 : 3'b000;
        check({tag, "/strobes"}, {buf_push, buf_pop, buf_read}, exp_strb);
        check({tag, "/issue_ready"}, req_ready, 0);
        if (op == 2'b00) check({tag, "/buf_data_in"}, buf_data_in, d);
        req_valid[w] = 1'b0;
        if (rst_in_issue) begin
            rst = 1'b1;
            @(negedge clk);
            #1;
            check({tag, "/rst_rsp_valid"}, rsp_valid, 0);
            check({tag, "/rst_count"}, count, 0);
            check({tag, "/rst_empty"}, empty, 1);
            check({tag, "/rst_buf_empty"}, cb_empty, 1);
            rst = 1'b0;
            q.delete();
            ptr_m = 0;
            $display("step %s: req %0d op %0d dropped by reset", tag, w, op);
            return;
        end
        exp_data = '0;
        case (op)
            2'b00: q.push_back(d);
            2'b01: exp_data = q.pop_front();
            2'b10: exp_data = q[0];
            default: ;
        endcase
        @(negedge clk);
        #1;
        check({tag, "/rsp_valid"}, rsp_valid, NR'(1) << w);
        check({tag, "/rsp_err"}, rsp_err, (op == 2'b11));
        check({tag, "/rsp_data"}, rsp_data, exp_data);
        check({tag, "/count"}, count, q.size());
        check({tag, "/full"}, full, (q.size() == DEPTH - 1));
        check({tag, "/empty"}, empty, (q.size() == 0));
        check({tag, "/resp_ready"}, req_ready, 0);
        $display("step %s: req %0d op %0d data %08h rsp %08h count %0d",
                 tag, w, op, d, rsp_data, count);
        @(negedge clk);
    endtask

    initial begin
        req_valid = '0;
        for (int r = 0; r < NR; r++) set_req(r, 2'b00, word_t'(r));
        do_reset("reset");
        req_valid = '0;

        set_req(0, 2'b00, 32'hA5);
        step("t1_push");
        set_req(1, 2'b01, 32'h0);
        step("t2_pop");

        do_reset("reset2");
        for (int r = 0; r < NR; r++) set_req(r, 2'b00, 32'h10 + word_t'(r));
        repeat (4) step("t3_push");
        for (int r = 0; r < NR; r++) set_req(r, 2'b01, 32'h0);
        repeat (4) step("t3_pop");

        for (int i = 0; i < DEPTH - 1; i++) begin
            set_req(i % NR, 2'b00, 32'h100 + word_t'(i));
            step("t4_fill");
        end
        set_req(2, 2'b00, 32'h99);
        set_req(3, 2'b01, 32'h0);
        step("t4_full");
        step("t4_resume");
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_req(i % NR, 2'b01, 32'h0);
            step("t4_drain");
        end

        set_req(0, 2'b01, 32'h0);
        set_req(2, 2'b10, 32'h0);
        set_req(1, 2'b11, 32'h0);
        step("t5_bad");
        step("t5_pending");
        req_valid = '0;

        set_req(0, 2'b00, 32'h5A);
        step("t6_push_rst", 1'b1);
        set_req(0, 2'b10, 32'h0);
        step("t6_read_blocked");
        set_req(1, 2'b00, 32'h77);
        step("t6_push");
        step("t6_read");
        req_valid = '0;

        for (int it = 0; it < 80; it++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
                    int x = $urandom_range(0, 9);
                    set_req(r, (x < 4) ? 2'b00 : (x < 7) ? 2'b01 : (x < 9) ? 2'b10 : 2'b11,
                            word_t'($urandom));
                end
            end
            if (predict() < 0 && req_valid == '1) req_valid[$urandom_range(0, NR - 1)] = 1'b0;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
